// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage boundaries: stage state
// encoding and control-bundle bit positions used by every stage.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int unsigned CTRL_REG_WRITE = 0;
    localparam int unsigned CTRL_MEM_READ  = 1;
    localparam int unsigned CTRL_MEM_WRITE = 2;
    localparam int unsigned CTRL_MEM_2_REG = 3;
    localparam int unsigned CTRL_BRANCH    = 4;
    localparam int unsigned CTRL_JUMP      = 5;
    localparam int unsigned CTRL_ALU_SRC   = 6;
    localparam int unsigned CTRL_REG_DST   = 7;

    function automatic logic [1:0] occ_of(input state_t s);
        case (s)
            ST_BUSY: occ_of = 2'd1;
            ST_FULL: occ_of = 2'd2;
            default: occ_of = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry (data + control) with async clear, load enable and a
// control-only clear that turns the held entry into a bubble.
module pipe_entry_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic              clr_ctrl,
    input  logic [DATA_W-1:0] next_data,
    input  logic [CTRL_W-1:0] next_ctrl,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            data <= '0;
            ctrl <= '0;
        end else if (clr_ctrl) begin
            ctrl <= '0;
        end else if (load) begin
            data <= next_data;
            ctrl <= next_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Clocked pipeline stage boundary with valid/ready handshake, stall, flush to
// bubble, global enable and an optional two-entry skid buffer.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    state_t            state;
    state_t            next_state;
    logic              in_ready_q;
    logic              flush_en;
    logic              accept;
    logic              take;
    logic              main_load;
    logic              skid_load;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] main_src_data;
    logic [CTRL_W-1:0] main_src_ctrl;

    assign flush_en  = enable & flush;
    assign out_valid = enable & (state != ST_EMPTY);
    assign in_ready  = (SKID != 0) ? (enable & in_ready_q)
                                   : (enable & ((state == ST_EMPTY) | out_ready));
    assign accept    = enable & in_valid & in_ready & ~flush;
    assign take      = enable & out_valid & out_ready;

    // Without a skid, accepting while BUSY implies out_ready, so take is also true.
    assign main_load = ~flush_en & (((state == ST_EMPTY) & accept)
                                  | ((state == ST_BUSY) & accept & take)
                                  | ((SKID != 0) & (state == ST_FULL) & take));
    assign skid_load = (SKID != 0) & (state == ST_BUSY) & accept & ~take;

    assign main_src_data = (state == ST_FULL) ? skid_data : in_data;
    assign main_src_ctrl = (state == ST_FULL) ? skid_ctrl : in_ctrl;

    always_comb begin
        next_state = state;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_BUSY;
            ST_BUSY: begin
                if (accept && !take) begin
                    if (SKID != 0) next_state = ST_FULL;
                    else           next_state = ST_BUSY;
                end else if (!accept && take) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (SKID == 0)  next_state = ST_EMPTY;
                else if (take)  next_state = ST_BUSY;
            end
            default: next_state = ST_EMPTY;
        endcase
        if (flush_en) next_state = ST_EMPTY;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= ST_EMPTY;
            in_ready_q <= 1'b1;
            occupancy  <= 2'd0;
        end else begin
            state     <= next_state;
            occupancy <= occ_of(next_state);
            if (enable) in_ready_q <= (next_state != ST_FULL);
        end
    end

    pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk       (clk),
        .arst_n    (arst_n),
        .load      (main_load),
        .clr_ctrl  (flush_en),
        .next_data (main_src_data),
        .next_ctrl (main_src_ctrl),
        .data      (main_data),
        .ctrl      (main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_entry_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk       (clk),
                .arst_n    (arst_n),
                .load      (skid_load),
                .clr_ctrl  (flush_en),
                .next_data (in_data),
                .next_ctrl (in_ctrl),
                .data      (skid_data),
                .ctrl      (skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    assign out_data = main_data;
    assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance for the main scenarios
// and a SKID=0 instance for the combinational in_ready behaviour.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        enable;
    logic        flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [7:0]  in_ctrl, out_ctrl;
    logic [1:0]  occupancy;

    logic        in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_data0, out_data0;
    logic [7:0]  in_ctrl0, out_ctrl0;
    logic [1:0]  occupancy0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) dut (
        .clk(clk), .arst_n(arst_n), .enable(enable), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ctrl(out_ctrl), .occupancy(occupancy)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) dut0 (
        .clk(clk), .arst_n(arst_n), .enable(enable), .flush(1'b0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0), .in_ctrl(in_ctrl0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occupancy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        arst_n = 1'b0; enable = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
        in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0; out_ready0 = 1'b0;
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_ctrl", {24'b0, out_ctrl}, 32'd0);
        check("rst_occ", {30'b0, occupancy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        arst_n = 1'b1;
        tick();

        // Streaming at full throughput
        in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h01; in_data = 32'h100;
        tick();
        check("stream0_data", out_data, 32'h100);
        check("stream0_occ", {30'b0, occupancy}, 32'd1);
        in_data = 32'h104;
        tick();
        check("stream1_data", out_data, 32'h104);
        check("stream1_rdy", {31'b0, in_ready}, 32'd1);
        in_data = 32'h108;
        tick();
        check("stream2_data", out_data, 32'h108);
        check("stream2_occ", {30'b0, occupancy}, 32'd1);
        check("stream2_ctrl", {24'b0, out_ctrl}, 32'h01);
        in_valid = 1'b0;
        tick();
        check("stream_drain_occ", {30'b0, occupancy}, 32'd0);
        check("stream_drain_valid", {31'b0, out_valid}, 32'd0);

        // Stall into skid
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hA;
        tick();
        in_data = 32'hB;
        tick();
        check("skid_occ", {30'b0, occupancy}, 32'd2);
        check("skid_in_ready", {31'b0, in_ready}, 32'd0);
        check("skid_head", out_data, 32'hA);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check("skid_second", out_data, 32'hB);
        check("skid_rdy_back", {31'b0, in_ready}, 32'd1);
        check("skid_occ1", {30'b0, occupancy}, 32'd1);
        tick();
        check("skid_empty", {30'b0, occupancy}, 32'd0);

        // Flush from FULL
        in_valid = 1'b1; out_ready = 1'b0; in_ctrl = 8'h3F; in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        check("pre_flush_occ", {30'b0, occupancy}, 32'd2);
        check("pre_flush_ctrl", {24'b0, out_ctrl}, 32'h3F);
        flush = 1'b1; in_data = 32'hC; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        check("flush_ctrl", {24'b0, out_ctrl}, 32'd0);
        check("flush_occ", {30'b0, occupancy}, 32'd0);
        check("flush_rdy", {31'b0, in_ready}, 32'd1);
        tick();
        check("flush_no_c", {31'b0, out_valid}, 32'd0);

        // Flush from BUSY drops the same-cycle input
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'hD;
        tick();
        flush = 1'b1; in_data = 32'hE;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_busy_occ", {30'b0, occupancy}, 32'd0);
        check("flush_busy_valid", {31'b0, out_valid}, 32'd0);

        // Enable freeze
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h55; in_ctrl = 8'h11;
        tick();
        enable = 1'b0; in_data = 32'h66; out_ready = 1'b1;
        #1;
        check("frz_in_ready", {31'b0, in_ready}, 32'd0);
        check("frz_out_valid", {31'b0, out_valid}, 32'd0);
        check("frz_out_ctrl", {24'b0, out_ctrl}, 32'd0);
        tick(); tick(); tick();
        check("frz_occ", {30'b0, occupancy}, 32'd1);
        enable = 1'b1; in_valid = 1'b0;
        #1;
        check("frz_resume_valid", {31'b0, out_valid}, 32'd1);
        check("frz_resume_data", out_data, 32'h55);
        check("frz_resume_ctrl", {24'b0, out_ctrl}, 32'h11);
        tick();
        check("frz_drained", {30'b0, occupancy}, 32'd0);

        // Async reset while FULL
        in_valid = 1'b1; out_ready = 1'b0; in_data = 32'h7; in_ctrl = 8'h22;
        tick();
        in_data = 32'h8;
        tick();
        check("mid_pre_occ", {30'b0, occupancy}, 32'd2);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_ctrl", {24'b0, out_ctrl}, 32'd0);
        check("mid_rst_occ", {30'b0, occupancy}, 32'd0);
        in_valid = 1'b0;
        tick();
        arst_n = 1'b1;
        #1;
        check("mid_rst_rdy", {31'b0, in_ready}, 32'd1);

        // SKID=0 instance
        in_valid0 = 1'b1; out_ready0 = 1'b0; in_data0 = 32'h20; in_ctrl0 = 8'h05;
        #1;
        check("s0_rdy_empty", {31'b0, in_ready0}, 32'd1);
        tick();
        check("s0_busy_rdy", {31'b0, in_ready0}, 32'd0);
        check("s0_head", out_data0, 32'h20);
        check("s0_ctrl", {24'b0, out_ctrl0}, 32'h05);
        in_data0 = 32'h21; out_ready0 = 1'b1;
        #1;
        check("s0_rdy_comb", {31'b0, in_ready0}, 32'd1);
        tick();
        check("s0_replace", out_data0, 32'h21);
        check("s0_occ", {30'b0, occupancy0}, 32'd1);
        in_valid0 = 1'b0;
        tick();
        check("s0_empty", {30'b0, occupancy0}, 32'd0);
        check("s0_empty_valid", {31'b0, out_valid0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
